mc_control: RTL and testbench
=============================

MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameter ILLEGAL_HALT, default 1, meaning: 1 = illegal opcode enters HALT; 0 = illegal opcode is retired as a NOP.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 opcode  input  7  instruction[6:0] from the instruction register via the decoder.
REQ-005 funct3  input  3  instruction[14:12]; bit 2 is unused here and is passed to the ALU decode.
REQ-006 mem_ready  input  1  shared instruction/data memory completes the current request this cycle.
REQ-007 branch_taken  input  1  branch comparator result; valid in EXEC.
REQ-008 mem_req  output  1  memory request.
REQ-009 mem_we  output  1  memory write.
REQ-010 mem_sel_data  output  1  memory address select: 0 = PC, 1 = ALU result.
REQ-011 ir_we  output  1  instruction register load.
REQ-012 pc_we  output  1  PC load.
REQ-013 pc_src  output  2  PC source: 00 = pc+4, 01 = pc+imm, 10 = ALU result with bit0 cleared.
REQ-014 alu_src_a  output  1  ALU operand A: 0 = rs1, 1 = pc.
REQ-015 alu_src_b  output  1  ALU operand B: 0 = rs2, 1 = immediate.
REQ-016 alu_op  output  2  ALU operation: 00 = add, 01 = compare, 10 = decode from funct3/funct7, 11 = pass B.
REQ-017 reg_we  output  1  register file write.
REQ-018 wb_sel  output  2  writeback source: 00 = ALU, 01 = memory, 10 = pc+4.
REQ-019 state  output  3  current state encoding.
REQ-020 halted  output  1  controller is in HALT.
REQ-021 illegal  output  1  sticky illegal-opcode flag.
REQ-022 instret  output  32  retired-instruction count.

Function
REQ-023 States and encodings SHALL be: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, HALT = 5; all other encodings SHALL go to FETCH.
REQ-024 Every strobe output SHALL be 0 in any state or cycle where it is not explicitly asserted below.
REQ-025 FETCH SHALL assert mem_req with mem_sel_data = 0 and mem_we = 0, and hold them until mem_ready = 1; in the mem_ready cycle it SHALL assert ir_we and go to DECODE.
REQ-026 DECODE SHALL register an instruction class from opcode:
- LOAD 0000011, STORE 0100011, OPIMM 0010011, OP 0110011, LUI 0110111, AUIPC 0010111, BRANCH 1100011, JAL 1101111, JALR 1100111, FENCE 0001111, SYSTEM 1110011, ILLEGAL (anything else).
- EXEC, MEM and WB SHALL use only this registered class, never the live opcode.
REQ-027 DECODE transitions:
- SYSTEM: go to HALT.
- FENCE: pc_we = 1, pc_src = 00, go to FETCH.
- ILLEGAL: set illegal; if ILLEGAL_HALT = 1, go to HALT; otherwise behave as FENCE.
- All other classes: go to EXEC.
REQ-028 EXEC outputs and next state, by class:
- OP: alu_op = 10, alu_src_b = 0, go to WB.
- OPIMM: alu_op = 10, alu_src_b = 1, go to WB.
- LUI: alu_op = 11, alu_src_b = 1, go to WB.
- AUIPC: alu_src_a = 1, alu_src_b = 1, alu_op = 00, go to WB.
- LOAD/STORE: alu_op = 00, alu_src_b = 1, go to MEM.
- BRANCH: alu_op = 01, pc_we = 1, pc_src = branch_taken ? 01 : 00, go to FETCH.
- JAL: reg_we = 1, wb_sel = 10, pc_we = 1, pc_src = 01, go to FETCH.
- JALR: alu_src_b = 1, alu_op = 00, reg_we = 1, wb_sel = 10, pc_we = 1, pc_src = 10, go to FETCH.
REQ-029 MEM SHALL assert mem_req with mem_sel_data = 1, mem_we = 1 for STORE, and hold the EXEC ALU controls; on mem_ready:
- STORE: pc_we = 1, pc_src = 00, go to FETCH.
- LOAD: go to WB.
REQ-030 WB SHALL assert reg_we = 1 and wb_sel = 01 for LOAD, else 00; it SHALL hold the EXEC ALU controls, assert pc_we = 1 with pc_src = 00, and go to FETCH.
REQ-031 mem_req SHALL deassert in the cycle after mem_ready is sampled high; mem_ready while mem_req = 0 SHALL be ignored.
REQ-032 instret SHALL increment by 1 in every cycle pc_we = 1, and wrap from 0xFFFFFFFF to 0.
REQ-033 HALT SHALL be absorbing until rst, with halted = 1 and all strobes 0.
REQ-034 Latency with zero-wait memory SHALL be: OP/OPIMM/LUI/AUIPC 4 cycles, LOAD 5, STORE 4, BRANCH/JAL/JALR 3, FENCE 2; each memory wait cycle adds 1.

Reset
REQ-035 While rst = 1 at a clock edge, the controller SHALL go to state = FETCH and clear instret, illegal and the class register; all outputs SHALL be 0 in the following cycle.
REQ-036 Reset asserted during FETCH or MEM wait SHALL drop mem_req in the next cycle, with no ir_we, pc_we or reg_we.
REQ-037 In the first cycle after reset release, the controller SHALL be in FETCH with mem_req = 1.

Verification
REQ-038 ADD (0110011), mem_ready always 1 -> states 0,1,2,4,0; reg_we = 1 and wb_sel = 00 in WB; instret 0 -> 1 after 4 cycles.
REQ-039 LW with mem_ready low for 3 cycles in MEM -> mem_req, mem_sel_data = 1 and mem_we = 0 held 4 cycles; WB has wb_sel = 01; total 8 cycles.
REQ-040 BEQ with branch_taken = 1, then again with 0 -> pc_src = 01 then 00, each in EXEC; 3 cycles each; reg_we never 1.
REQ-041 opcode 0000000 with ILLEGAL_HALT = 1 -> illegal = 1, state = 5, halted = 1, instret unchanged; with ILLEGAL_HALT = 0 -> pc_we with pc_src = 00 in DECODE, back to FETCH.
REQ-042 rst pulsed in the 2nd wait cycle of a STORE MEM -> mem_req = 0 in the next cycle, no pc_we, instret = 0, state = 0.
REQ-043 Preload instret = 0xFFFFFFFF by retiring instructions in a long run, then JAL -> instret = 0, with wb_sel = 10 and pc_src = 01.

Source files
------------

// File: rtl/mc_control.sv
// Multi-cycle control FSM for a shared-memory RV32I-style datapath.
// One instruction walks FETCH -> DECODE -> (EXEC -> (MEM) -> (WB)) and retires on pc_we.
module mc_control #(
  parameter int ILLEGAL_HALT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        mem_ready,
  input  logic        branch_taken,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_sel_data,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        alu_src_a,
  output logic        alu_src_b,
  output logic [1:0]  alu_op,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic [2:0]  state,
  output logic        halted,
  output logic        illegal,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_ILLEGAL, C_LOAD, C_STORE, C_OPIMM, C_OP, C_LUI, C_AUIPC,
    C_BRANCH, C_JAL, C_JALR, C_FENCE, C_SYSTEM
  } class_t;

  state_t      state_reg, state_next;
  class_t      class_reg, class_dec;
  logic        blank_reg;
  logic        illegal_reg, set_illegal;
  logic [31:0] instret_reg;
  logic        alu_a_c, alu_b_c;
  logic [1:0]  alu_op_c;

  // funct3 is consumed by the ALU decoder, not by this controller.
  logic unused_funct3;
  assign unused_funct3 = ^funct3;

  always_comb begin
    case (opcode)
      7'b0000011: class_dec = C_LOAD;
      7'b0100011: class_dec = C_STORE;
      7'b0010011: class_dec = C_OPIMM;
      7'b0110011: class_dec = C_OP;
      7'b0110111: class_dec = C_LUI;
      7'b0010111: class_dec = C_AUIPC;
      7'b1100011: class_dec = C_BRANCH;
      7'b1101111: class_dec = C_JAL;
      7'b1100111: class_dec = C_JALR;
      7'b0001111: class_dec = C_FENCE;
      7'b1110011: class_dec = C_SYSTEM;
      default:    class_dec = C_ILLEGAL;
    endcase
  end

  // ALU controls chosen in EXEC and held unchanged through MEM and WB.
  always_comb begin
    alu_a_c  = 1'b0;
    alu_b_c  = 1'b0;
    alu_op_c = 2'b00;
    case (class_reg)
      C_OP:             alu_op_c = 2'b10;
      C_OPIMM:          begin alu_op_c = 2'b10; alu_b_c = 1'b1; end
      C_LUI:            begin alu_op_c = 2'b11; alu_b_c = 1'b1; end
      C_AUIPC:          begin alu_a_c = 1'b1; alu_b_c = 1'b1; end
      C_LOAD, C_STORE:  alu_b_c = 1'b1;
      C_BRANCH:         alu_op_c = 2'b01;
      C_JALR:           alu_b_c = 1'b1;
      default:          ;
    endcase
  end

  always_comb begin
    state_next   = state_reg;
    set_illegal  = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_sel_data = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = 2'b00;
    alu_src_a    = 1'b0;
    alu_src_b    = 1'b0;
    alu_op       = 2'b00;
    reg_we       = 1'b0;
    wb_sel       = 2'b00;
    halted       = 1'b0;
    // The cycle right after reset is blanked so every output reads 0.
    if (!blank_reg) begin
      case (state_reg)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_we      = 1'b1;
            state_next = S_DECODE;
          end
        end
        S_DECODE: begin
          case (class_dec)
            C_SYSTEM: state_next = S_HALT;
            C_FENCE: begin
              pc_we      = 1'b1;
              state_next = S_FETCH;
            end
            C_ILLEGAL: begin
              set_illegal = 1'b1;
              if (ILLEGAL_HALT != 0) begin
                state_next = S_HALT;
              end else begin
                pc_we      = 1'b1;
                state_next = S_FETCH;
              end
            end
            default: state_next = S_EXEC;
          endcase
        end
        S_EXEC: begin
          alu_src_a = alu_a_c;
          alu_src_b = alu_b_c;
          alu_op    = alu_op_c;
          case (class_reg)
            C_OP, C_OPIMM, C_LUI, C_AUIPC: state_next = S_WB;
            C_LOAD, C_STORE:               state_next = S_MEM;
            C_BRANCH: begin
              pc_we      = 1'b1;
              pc_src     = branch_taken ? 2'b01 : 2'b00;
              state_next = S_FETCH;
            end
            C_JAL, C_JALR: begin
              reg_we     = 1'b1;
              wb_sel     = 2'b10;
              pc_we      = 1'b1;
              pc_src     = (class_reg == C_JAL) ? 2'b01 : 2'b10;
              state_next = S_FETCH;
            end
            default: state_next = S_FETCH;
          endcase
        end
        S_MEM: begin
          mem_req      = 1'b1;
          mem_sel_data = 1'b1;
          mem_we       = (class_reg == C_STORE);
          alu_src_a    = alu_a_c;
          alu_src_b    = alu_b_c;
          alu_op       = alu_op_c;
          if (mem_ready) begin
            if (class_reg == C_STORE) begin
              pc_we      = 1'b1;
              state_next = S_FETCH;
            end else begin
              state_next = S_WB;
            end
          end
        end
        S_WB: begin
          reg_we     = 1'b1;
          wb_sel     = (class_reg == C_LOAD) ? 2'b01 : 2'b00;
          alu_src_a  = alu_a_c;
          alu_src_b  = alu_b_c;
          alu_op     = alu_op_c;
          pc_we      = 1'b1;
          state_next = S_FETCH;
        end
        S_HALT:  halted = 1'b1;
        default: state_next = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_FETCH;
      class_reg   <= C_ILLEGAL;
      blank_reg   <= 1'b1;
      illegal_reg <= 1'b0;
      instret_reg <= 32'd0;
    end else begin
      blank_reg <= 1'b0;
      state_reg <= state_next;
      if (state_reg == S_DECODE) class_reg <= class_dec;
      if (set_illegal) illegal_reg <= 1'b1;
      if (pc_we) instret_reg <= instret_reg + 32'd1;
    end
  end

  assign state   = state_reg;
  assign illegal = illegal_reg;
  assign instret = instret_reg;

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: one trace line per instruction, checks via check().
`timescale 1ns/1ps
module tb_mc_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        mem_ready, branch_taken;

  logic        mem_req, mem_we, mem_sel_data, ir_we, pc_we;
  logic [1:0]  pc_src, alu_op, wb_sel;
  logic        alu_src_a, alu_src_b, reg_we, halted, illegal;
  logic [2:0]  st;
  logic [31:0] instret;

  logic        n_mem_req, n_mem_we, n_mem_sel_data, n_ir_we, n_pc_we;
  logic [1:0]  n_pc_src, n_alu_op, n_wb_sel;
  logic        n_alu_src_a, n_alu_src_b, n_reg_we, n_halted, n_illegal;
  logic [2:0]  n_st;
  logic [31:0] n_instret;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] trace;
  int          ncyc, rw_cnt, memd_cnt, memwe_cnt;
  logic [1:0]  pcsrc_seen, wbsel_seen;
  logic [2:0]  pcwe_state;
  logic [3:0]  exec_alu, wb_alu;

  localparam logic [6:0] OP_ADD   = 7'b0110011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_FENCE = 7'b0001111;

  always #5 clk = ~clk;

  mc_control #(.ILLEGAL_HALT(1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
    .mem_ready(mem_ready), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel_data(mem_sel_data),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_we(reg_we), .wb_sel(wb_sel), .state(st), .halted(halted),
    .illegal(illegal), .instret(instret)
  );

  mc_control #(.ILLEGAL_HALT(0)) dut_nop (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
    .mem_ready(mem_ready), .branch_taken(branch_taken),
    .mem_req(n_mem_req), .mem_we(n_mem_we), .mem_sel_data(n_mem_sel_data),
    .ir_we(n_ir_we), .pc_we(n_pc_we), .pc_src(n_pc_src),
    .alu_src_a(n_alu_src_a), .alu_src_b(n_alu_src_b), .alu_op(n_alu_op),
    .reg_we(n_reg_we), .wb_sel(n_wb_sel), .state(n_st), .halted(n_halted),
    .illegal(n_illegal), .instret(n_instret)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Feeds one instruction from FETCH until the DUT is back in FETCH, recording what it did.
  task automatic run_instr(input string tag, input logic [6:0] op, input logic bt, input int mwait);
    int  left;
    bit  done;
    left = mwait; done = 1'b0;
    trace = '0; ncyc = 0; rw_cnt = 0; memd_cnt = 0; memwe_cnt = 0;
    pcsrc_seen = 2'b11; wbsel_seen = 2'b11; pcwe_state = 3'd7;
    exec_alu = 4'hf; wb_alu = 4'hf;
    for (int c = 0; c < 24 && !done; c++) begin
      opcode = op;
      branch_taken = bt;
      if (st == 3'd3) begin
        mem_ready = (left == 0);
        if (left > 0) left--;
      end else begin
        mem_ready = 1'b1;
      end
      #1;
      trace = {trace[27:0], 1'b0, st};
      ncyc++;
      if (reg_we) begin rw_cnt++; wbsel_seen = wb_sel; end
      if (mem_req && mem_sel_data) memd_cnt++;
      if (mem_we) memwe_cnt++;
      if (pc_we) begin pcsrc_seen = pc_src; pcwe_state = st; end
      if (st == 3'd2) exec_alu = {alu_src_a, alu_src_b, alu_op};
      if (st == 3'd4) wb_alu = {alu_src_a, alu_src_b, alu_op};
      @(negedge clk);
      if (st == 3'd0) done = 1'b1;
    end
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    $display("instr %-6s op=%b cycles=%0d trace=%0h instret=%0d", tag, op, ncyc, trace, instret);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; opcode = '0; funct3 = '0; mem_ready = 1'b0; branch_taken = 1'b0;
    @(negedge clk); #1;
    check("rst_state", {29'd0, st}, 32'd0);
    check("rst_memreq", {31'd0, mem_req}, 32'd0);
    check("rst_instret", instret, 32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    rst = 1'b0;
    @(negedge clk); #1;
    check("rel_memreq", {31'd0, mem_req}, 32'd1);
    check("rel_state", {29'd0, st}, 32'd0);

    run_instr("add", OP_ADD, 1'b0, 0);
    check("add_trace", trace, 32'h0124);
    check("add_rw", rw_cnt, 32'd1);
    check("add_wbsel", {30'd0, wbsel_seen}, 32'd0);
    check("add_alu", {28'd0, exec_alu}, 32'h2);
    check("add_instret", instret, 32'd1);

    run_instr("lw", OP_LW, 1'b0, 3);
    check("lw_trace", trace, 32'h01233334);
    check("lw_cycles", ncyc, 32'd8);
    check("lw_memdata", memd_cnt, 32'd4);
    check("lw_memwe", memwe_cnt, 32'd0);
    check("lw_wbsel", {30'd0, wbsel_seen}, 32'd1);
    check("lw_wbalu", {28'd0, wb_alu}, 32'h4);
    check("lw_instret", instret, 32'd2);

    run_instr("sw", OP_SW, 1'b0, 0);
    check("sw_trace", trace, 32'h0123);
    check("sw_memwe", memwe_cnt, 32'd1);
    check("sw_rw", rw_cnt, 32'd0);
    check("sw_pcwe_state", {29'd0, pcwe_state}, 32'd3);

    run_instr("beq_t", OP_BEQ, 1'b1, 0);
    check("beqt_trace", trace, 32'h012);
    check("beqt_pcsrc", {30'd0, pcsrc_seen}, 32'd1);
    check("beqt_pcwe_state", {29'd0, pcwe_state}, 32'd2);
    check("beqt_rw", rw_cnt, 32'd0);
    check("beqt_alu", {28'd0, exec_alu}, 32'h1);

    run_instr("beq_n", OP_BEQ, 1'b0, 0);
    check("beqn_cycles", ncyc, 32'd3);
    check("beqn_pcsrc", {30'd0, pcsrc_seen}, 32'd0);
    check("beqn_rw", rw_cnt, 32'd0);

    run_instr("jal", OP_JAL, 1'b0, 0);
    check("jal_trace", trace, 32'h012);
    check("jal_wbsel", {30'd0, wbsel_seen}, 32'd2);
    check("jal_pcsrc", {30'd0, pcsrc_seen}, 32'd1);

    run_instr("jalr", OP_JALR, 1'b0, 0);
    check("jalr_pcsrc", {30'd0, pcsrc_seen}, 32'd2);
    check("jalr_alu", {28'd0, exec_alu}, 32'h4);

    run_instr("lui", OP_LUI, 1'b0, 0);
    check("lui_alu", {28'd0, exec_alu}, 32'h7);
    check("lui_wbalu", {28'd0, wb_alu}, 32'h7);
    run_instr("auipc", OP_AUIPC, 1'b0, 0);
    check("auipc_alu", {28'd0, exec_alu}, 32'hc);
    run_instr("opimm", OP_IMM, 1'b0, 0);
    check("opimm_alu", {28'd0, exec_alu}, 32'h6);

    run_instr("fence", OP_FENCE, 1'b0, 0);
    check("fence_trace", trace, 32'h01);
    check("fence_pcwe_state", {29'd0, pcwe_state}, 32'd1);
    check("seq_instret", instret, 32'd11);

    // Reset landing in the second wait cycle of a store's MEM phase.
    opcode = OP_SW; mem_ready = 1'b1;
    @(negedge clk); @(negedge clk); @(negedge clk);
    #1;
    check("rsw_in_mem", {29'd0, st}, 32'd3);
    mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; #1;
    check("rsw_memreq", {31'd0, mem_req}, 32'd0);
    check("rsw_pcwe", {31'd0, pc_we}, 32'd0);
    check("rsw_instret", instret, 32'd0);
    check("rsw_state", {29'd0, st}, 32'd0);
    $display("instr rst_sw state=%0d mem_req=%b instret=%0d", st, mem_req, instret);
    @(negedge clk); #1;
    check("rsw_rel_memreq", {31'd0, mem_req}, 32'd1);

    run_instr("add2", OP_ADD, 1'b0, 0);
    check("add2_instret", instret, 32'd1);

    // Illegal opcode: dut halts, dut_nop retires it as a NOP from DECODE.
    opcode = 7'b0000000; mem_ready = 1'b1;
    @(negedge clk); #1;
    check("ill_decode_state", {29'd0, st}, 32'd1);
    check("ill_nop_pcwe", {31'd0, n_pc_we}, 32'd1);
    check("ill_nop_pcsrc", {30'd0, n_pc_src}, 32'd0);
    check("ill_halt_pcwe", {31'd0, pc_we}, 32'd0);
    @(negedge clk); #1;
    check("ill_state", {29'd0, st}, 32'd5);
    check("ill_halted", {31'd0, halted}, 32'd1);
    check("ill_flag", {31'd0, illegal}, 32'd1);
    check("ill_instret", instret, 32'd1);
    check("ill_memreq", {31'd0, mem_req}, 32'd0);
    check("ill_nop_state", {29'd0, n_st}, 32'd0);
    check("ill_nop_flag", {31'd0, n_illegal}, 32'd1);
    check("ill_nop_instret", n_instret, 32'd2);
    $display("instr illegal state=%0d halted=%b nop_state=%0d", st, halted, n_st);
    opcode = OP_ADD;
    @(negedge clk); @(negedge clk); @(negedge clk); #1;
    check("halt_absorb", {29'd0, st}, 32'd5);
    check("halt_memreq", {31'd0, mem_req}, 32'd0);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    check("post_rst_illegal", {31'd0, illegal}, 32'd0);
    check("post_rst_state", {29'd0, st}, 32'd0);

    for (int i = 0; i < 4; i++) begin
      run_instr("l_add", OP_ADD, 1'b0, 0);
      run_instr("l_lui", OP_LUI, 1'b0, 0);
      run_instr("l_beq", OP_BEQ, 1'b0, 0);
      run_instr("l_fence", OP_FENCE, 1'b0, 0);
      run_instr("l_sw", OP_SW, 1'b0, 1);
    end
    check("long_instret", instret, 32'd20);

    // Jump the counter to its top value rather than retiring 2^32 instructions.
    force dut.instret_reg = 32'hFFFF_FFFF;
    #1;
    release dut.instret_reg;
    run_instr("jal_w", OP_JAL, 1'b0, 0);
    check("wrap_instret", instret, 32'd0);
    check("wrap_wbsel", {30'd0, wbsel_seen}, 32'd2);
    check("wrap_pcsrc", {30'd0, pcsrc_seen}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
